// File: rtl/registrador_deslocamento_param_if.sv
// Bus bundle for the parametrised universal shift register: load/shift
// requests toward the register and Q/status back from it.
interface registrador_deslocamento_param_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic [WIDTH-1:0] D;
    logic             load;
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amount;
    logic             serial_in;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;
    logic             serial_out;
    logic             busy;
    logic             done;
    logic             zero;

    modport master (
        output D, load, start, mode, amount, serial_in,
        input  Q, Qn, serial_out, busy, done, zero
    );

    modport slave (
        input  D, load, start, mode, amount, serial_in,
        output Q, Qn, serial_out, busy, done, zero
    );
endinterface

// File: rtl/registrador_deslocamento_param.sv
// Universal register: parallel load plus a one-bit-per-clock shift/rotate
// engine sequenced by an IDLE/SHIFT FSM with a down-counter.
module registrador_deslocamento_param #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    registrador_deslocamento_param_if.slave bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [2:0]       MODE_SHL = 3'b000;
    localparam logic [2:0]       MODE_SHR = 3'b001;
    localparam logic [2:0]       MODE_SAR = 3'b010;
    localparam logic [2:0]       MODE_ROL = 3'b011;
    localparam logic [2:0]       MODE_ROR = 3'b100;
    localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
    localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    // One 1-bit step; result is {bit leaving the register, new contents}.
    // Reserved modes return the current serial_out and contents untouched.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] q,
        input logic             so,
        input logic [2:0]       m,
        input logic             sin
    );
        logic [WIDTH:0] r;
        case (m)
            MODE_SHL: r = {q[WIDTH-1], q[WIDTH-2:0], sin};
            MODE_SHR: r = {q[0], sin, q[WIDTH-1:1]};
            MODE_SAR: r = {q[0], q[WIDTH-1], q[WIDTH-1:1]};
            MODE_ROL: r = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR: r = {q[0], q[0], q[WIDTH-1:1]};
            default:  r = {so, q};
        endcase
        return r;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [AMT_W-1:0] cnt_r;
    logic [AMT_W-1:0] cnt_nxt_s;
    logic [2:0]       mode_r;
    logic [2:0]       mode_nxt_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qn_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             sout_r;
    logic             sout_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic [WIDTH:0]   step_s;

    assign step_s = shift_step(q_r, sout_r, mode_r, bus.serial_in);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.load) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.start && (bus.amount != CNT_ZERO)) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output/datapath next values; all of them are registered below
    always_comb begin
        q_nxt_s    = q_r;
        sout_nxt_s = sout_r;
        done_nxt_s = 1'b0;
        cnt_nxt_s  = cnt_r;
        mode_nxt_s = mode_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.load) begin
                    q_nxt_s = bus.D;
                end else if (bus.start) begin
                    mode_nxt_s = bus.mode;
                    cnt_nxt_s  = bus.amount;
                    // A zero-length request completes immediately without shifting.
                    if (bus.amount == CNT_ZERO) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        done_nxt_s = 1'b0;
                    end
                end else begin
                    q_nxt_s = q_r;
                end
            end
            ST_SHIFT: begin
                q_nxt_s    = step_s[WIDTH-1:0];
                sout_nxt_s = step_s[WIDTH];
                cnt_nxt_s  = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    done_nxt_s = 1'b1;
                end else begin
                    done_nxt_s = 1'b0;
                end
            end
            default: begin
                q_nxt_s = q_r;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_SHIFT);
    end

    // Datapath and status registers; Qn is kept as a registered complement
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r    <= {WIDTH{1'b0}};
            qn_r   <= {WIDTH{1'b1}};
            sout_r <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
            cnt_r  <= CNT_ZERO;
            mode_r <= 3'b000;
        end else begin
            q_r    <= q_nxt_s;
            qn_r   <= ~q_nxt_s;
            sout_r <= sout_nxt_s;
            done_r <= done_nxt_s;
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_nxt_s;
            mode_r <= mode_nxt_s;
        end
    end

    assign bus.Q          = q_r;
    assign bus.Qn         = qn_r;
    assign bus.serial_out = sout_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.zero       = (q_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_registrador_deslocamento_param.sv
// Scoreboard bench: expected per-step Q/serial_out pushed when a shift is
// requested, popped and compared as the register steps.
module tb_registrador_deslocamento_param;

    typedef struct packed {
        logic [7:0] q;
        logic       so;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [7:0] q_m;
    logic       sout_m;
    exp_t       exp_q[$];

    registrador_deslocamento_param_if #(.WIDTH(8), .AMT_W(4)) bus ();

    registrador_deslocamento_param #(.WIDTH(8), .AMT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model_step(input logic [7:0] q, input logic so,
                                        input logic [2:0] m, input logic sin);
        exp_t r;
        case (m)
            3'd0: begin r.q = (q << 1) | {7'd0, sin};          r.so = q[7]; end
            3'd1: begin r.q = (q >> 1) | {sin, 7'd0};          r.so = q[0]; end
            3'd2: begin r.q = (q >> 1) | {q[7], 7'd0};         r.so = q[0]; end
            3'd3: begin r.q = (q << 1) | {7'd0, q[7]};         r.so = q[7]; end
            3'd4: begin r.q = (q >> 1) | {q[0], 7'd0};         r.so = q[0]; end
            default: begin r.q = q; r.so = so; end
        endcase
        return r;
    endfunction

    task automatic load_value(input logic [7:0] v);
        bus.load = 1'b1;
        bus.D    = v;
        @(negedge clk);
        bus.load = 1'b0;
        q_m = v;
        checks++;
        if (bus.Q !== v) begin
            errors++;
            $display("FAIL load_value: Q=%h expected %h", bus.Q, v);
        end
    endtask

    task automatic do_shift(input logic [2:0] m, input logic [3:0] amt,
                            input logic sin, input bit interfere);
        exp_t e;
        logic [7:0] q0;
        int n;
        n  = amt;
        q0 = q_m;
        for (int i = 0; i < n; i++) begin
            e = model_step(q_m, sout_m, m, sin);
            q_m = e.q;
            sout_m = e.so;
            exp_q.push_back(e);
        end
        bus.start = 1'b1;
        bus.mode = m;
        bus.amount = amt;
        bus.serial_in = sin;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== (n != 0) || bus.done !== (n == 0) || bus.Q !== q0) begin
            errors++;
            $display("FAIL start_edge m=%0d amt=%0d: busy=%b done=%b Q=%h expected busy=%b done=%b Q=%h",
                     m, n, bus.busy, bus.done, bus.Q, (n != 0), (n == 0), q0);
        end
        for (int i = 0; i < n; i++) begin
            if (interfere && i == 0) begin
                bus.load = 1'b1;
                bus.D = 8'hFF;
                bus.start = 1'b1;
            end
            @(negedge clk);
            if (interfere && i == 0) begin
                bus.load = 1'b0;
                bus.start = 1'b0;
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty m=%0d step=%0d", m, i);
            end else begin
                e = exp_q.pop_front();
                if (bus.Q !== e.q || bus.Qn !== ~e.q || bus.serial_out !== e.so ||
                    bus.busy !== (i != n - 1) || bus.done !== (i == n - 1)) begin
                    errors++;
                    $display("FAIL step m=%0d step=%0d: Q=%h Qn=%h so=%b busy=%b done=%b expected Q=%h Qn=%h so=%b busy=%b done=%b",
                             m, i, bus.Q, bus.Qn, bus.serial_out, bus.busy, bus.done,
                             e.q, ~e.q, e.so, (i != n - 1), (i == n - 1));
                end
            end
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Q !== q_m) begin
            errors++;
            $display("FAIL after_done m=%0d: done=%b busy=%b Q=%h expected done=0 busy=0 Q=%h",
                     m, bus.done, bus.busy, bus.Q, q_m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.Q !== 8'h00 || bus.Qn !== 8'hFF || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.serial_out !== 1'b0 || bus.zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: Q=%h Qn=%h busy=%b done=%b so=%b zero=%b expected 00 FF 0 0 0 1",
                     bus.Q, bus.Qn, bus.busy, bus.done, bus.serial_out, bus.zero);
        end
        rst = 1'b1;
        load_value(8'h5A);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.Q !== 8'h00 || bus.Qn !== 8'hFF || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: Q=%h Qn=%h busy=%b expected Q=00 Qn=FF busy=0",
                     bus.Q, bus.Qn, bus.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        q_m = 8'h00;
        sout_m = 1'b0;
    endtask

    task automatic test_load();
        load_value(8'hA5);
        checks++;
        if (bus.Qn !== 8'h5A || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL load_qn_zero: Qn=%h zero=%b expected Qn=5A zero=0", bus.Qn, bus.zero);
        end
        @(negedge clk);
        checks++;
        if (bus.Q !== 8'hA5) begin
            errors++;
            $display("FAIL load_hold: Q=%h expected A5", bus.Q);
        end
    endtask

    task automatic test_shl();
        load_value(8'h81);
        do_shift(3'b000, 4'd3, 1'b0, 1'b0);
        checks++;
        if (bus.Q !== 8'h08) begin
            errors++;
            $display("FAIL shl_final: Q=%h expected 08", bus.Q);
        end
    endtask

    task automatic test_sar_shr();
        load_value(8'h96);
        do_shift(3'b010, 4'd2, 1'b0, 1'b0);
        checks++;
        if (bus.Q !== 8'hE5 || bus.serial_out !== 1'b1) begin
            errors++;
            $display("FAIL sar_final: Q=%h so=%b expected Q=E5 so=1", bus.Q, bus.serial_out);
        end
        do_shift(3'b001, 4'd9, 1'b1, 1'b0);
        checks++;
        if (bus.Q !== 8'hFF) begin
            errors++;
            $display("FAIL shr_saturate: Q=%h expected FF", bus.Q);
        end
    endtask

    task automatic test_rotate_zero();
        load_value(8'h3C);
        do_shift(3'b100, 4'd8, 1'b0, 1'b0);
        checks++;
        if (bus.Q !== 8'h3C) begin
            errors++;
            $display("FAIL ror_wrap: Q=%h expected 3C", bus.Q);
        end
        do_shift(3'b011, 4'd11, 1'b0, 1'b0);
        do_shift(3'b000, 4'd0, 1'b1, 1'b0);
        do_shift(3'b110, 4'd2, 1'b1, 1'b0);
    endtask

    task automatic test_interlock();
        load_value(8'h81);
        do_shift(3'b000, 4'd3, 1'b1, 1'b1);
        bus.load = 1'b1;
        bus.D = 8'h5A;
        bus.start = 1'b1;
        bus.mode = 3'b000;
        bus.amount = 4'd3;
        @(negedge clk);
        bus.load = 1'b0;
        bus.start = 1'b0;
        q_m = 8'h5A;
        checks++;
        if (bus.Q !== 8'h5A || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL load_start_priority: Q=%h busy=%b expected Q=5A busy=0", bus.Q, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.Q !== 8'h5A || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL load_start_no_seq: Q=%h busy=%b done=%b expected 5A 0 0",
                     bus.Q, bus.busy, bus.done);
        end
    endtask

    task automatic test_abort();
        bit seen;
        load_value(8'hF0);
        bus.start = 1'b1;
        bus.mode = 3'b000;
        bus.amount = 4'd5;
        bus.serial_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.Q !== 8'h00 || bus.busy !== 1'b0 || bus.serial_out !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: Q=%h busy=%b so=%b done=%b expected 00 0 0 0",
                     bus.Q, bus.busy, bus.serial_out, bus.done);
        end
        @(negedge clk);
        rst = 1'b1;
        q_m = 8'h00;
        sout_m = 1'b0;
        exp_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_done: done/busy observed=1 expected 0");
        end
        load_value(8'h81);
        do_shift(3'b000, 4'd3, 1'b0, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.D = 8'h00;
        bus.load = 1'b0;
        bus.start = 1'b0;
        bus.mode = 3'b000;
        bus.amount = 4'd0;
        bus.serial_in = 1'b0;
        q_m = 8'h00;
        sout_m = 1'b0;
        test_reset();
        test_load();
        test_shl();
        test_sar_shr();
        test_rotate_zero();
        test_interlock();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/registrador_deslocamento_param.md
Name: registrador_deslocamento_param

Overview:
Parametrised universal register: parallel load plus an iterative multi-bit shift/rotate engine with a start/busy/done handshake.
- Shifts one bit per clock under an FSM with a down-counter.
- Next-generation storage element for the ULA datapath: holds operands and performs SHL/SHR/SAR/ROL/ROR on them.
- Keeps the Q/Qn output pair.

Parameters:
WIDTH, 8, data width in bits (>=2)
AMT_W, 4, width of shift-amount input; must satisfy 2^AMT_W > WIDTH (default covers amounts 0..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low; clears all state
D  input  WIDTH  parallel load data
load  input  1  parallel load request, active-high
start  input  1  shift request, active-high, sampled only in IDLE
mode  input  3  shift operation, sampled with start
amount  input  AMT_W  number of 1-bit steps, sampled with start
serial_in  input  1  fill bit for SHL/SHR
Q  output  WIDTH  register contents
Qn  output  WIDTH  bitwise complement of Q
serial_out  output  1  last bit shifted/rotated out (registered)
busy  output  1  high while shift sequence in progress
done  output  1  one-cycle pulse on completion
zero  output  1  combinational, Q == 0

Behaviour:
- Reset (rst=0, async, no clock needed):
  - Q=0, Qn=all ones, serial_out=0, busy=0, done=0.
  - Counter=0, latched mode=0, state=IDLE.
  - Reset mid-sequence aborts the sequence with no done pulse.
- States: IDLE, SHIFT. busy is a registered output, high exactly in SHIFT.
- IDLE, per rising edge:
  - load=1: Q<=D. load has priority and start is ignored that cycle.
  - start=1 and load=0: latch mode and amount.
    - amount==0: stay IDLE, Q unchanged, done=1 next cycle.
    - Otherwise: go to SHIFT, counter<=amount, busy=1.
  - Neither asserted: Q holds.
- SHIFT, per edge: apply one 1-bit step, counter<=counter-1.
  - On the edge where counter==1: apply the final step, go to IDLE, busy<=0, done<=1 for exactly one cycle.
  - Total: start sampled at edge k; steps at edges k+1..k+N; done high between edges k+N and k+N+1.
- Steps (latched mode; the step sets serial_out to the bit leaving the register):
  - 000 SHL: Q<={Q[W-2:0],serial_in}, out=Q[W-1].
  - 001 SHR: Q<={serial_in,Q[W-1:1]}, out=Q[0].
  - 010 SAR: Q<={Q[W-1],Q[W-1:1]}, out=Q[0].
  - 011 ROL: Q<={Q[W-2:0],Q[W-1]}, out=Q[W-1].
  - 100 ROR: Q<={Q[0],Q[W-1:1]}, out=Q[0].
  - 101-111 reserved: Q and serial_out unchanged, but the sequence still runs N cycles and pulses done.
- Amounts > WIDTH are executed literally, without clamping:
  - Rotates wrap modulo WIDTH.
  - Shifts saturate to the fill pattern.
- In SHIFT, load and start are ignored. mode, amount and serial_in may change freely; serial_in is sampled every step.
- Qn = ~Q at all times. zero derives combinationally from Q.
- serial_out changes only on steps of modes 000-100 and on reset.
- done never coincides with busy=1. start may be reasserted in the cycle done is high; it begins a new sequence.

Test Plan:
1. Reset and load: assert rst=0 between clock edges → Q=00, Qn=FF, busy=0 immediately, with no clock edge. Release rst, load=1, D=A5 → after one edge Q=A5, Qn=5A, zero=0. Drop load → Q holds A5.
2. SHL: Q=81, start with mode=000, amount=3, serial_in=0 → Q steps 02, 04, 08 over edges k+1..k+3; serial_out 1, 0, 0; busy high for 3 cycles; done pulses once; final Q=08.
3. SAR then SHR: Q=96, SAR amount=2 → CB then E5, serial_out 0 then 1. Then SHR amount=9, serial_in=1 → Q=FF after 9 steps, done after edge k+9.
4. Rotate and zero amount: Q=3C, ROR amount=8 → Q=3C after 8 cycles, done once. Start with amount=0 → no busy, done next cycle, Q=3C. Reserved mode 110, amount=2 → Q unchanged, done after 2 cycles.
5. Busy interlocks: during an SHL sequence, assert load=1 with D=FF and start=1 → both ignored and the sequence completes normally. In IDLE, load=1 and start=1 together → Q<=D and no sequence starts.
6. Abort: rst=0 mid-sequence (step 2 of 5) → Q=00, busy=0, serial_out=0 immediately; no done pulse after rst is released. The next start operates normally.
